// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel button synchroniser, debouncer and press/release/long-press pulse generator
module button_debounce #(
    parameter int NUM_BTN        = 2,
    parameter int ACTIVE_LOW     = 1,
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
    localparam logic [NUM_BTN-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_PEND,
        S_PRESSED,
        S_RELEASE_PEND
    } state_t;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] samp;
    logic [TW-1:0]      tick_cnt;
    logic               tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign samp = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [DW-1:0] db_cnt, db_nxt;
        logic [HW-1:0] hold_cnt, hold_nxt;
        logic          press_nxt, release_nxt, long_nxt, level_nxt;
        logic          level_q, press_q, release_q, long_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= S_RELEASED;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                db_cnt    <= db_nxt;
                hold_cnt  <= hold_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            db_nxt      = db_cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            if (tick) begin
                case (state)
                    S_RELEASED: begin
                        if (samp[i]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_nxt = S_PRESSED;
                                press_nxt = 1'b1;
                            end else begin
                                state_nxt = S_PRESS_PEND;
                                db_nxt    = DW'(1);
                            end
                        end
                    end
                    S_PRESS_PEND: begin
                        if (!samp[i]) begin
                            state_nxt = S_RELEASED;
                            db_nxt    = '0;
                        end else if (db_cnt == DB_LAST) begin
                            state_nxt = S_PRESSED;
                            db_nxt    = '0;
                            press_nxt = 1'b1;
                        end else begin
                            db_nxt = db_cnt + 1'b1;
                        end
                    end
                    S_PRESSED: begin
                        if (!samp[i]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_nxt   = S_RELEASED;
                                release_nxt = 1'b1;
                            end else begin
                                state_nxt = S_RELEASE_PEND;
                                db_nxt    = DW'(1);
                            end
                        end
                    end
                    S_RELEASE_PEND: begin
                        if (samp[i]) begin
                            state_nxt = S_PRESSED;
                            db_nxt    = '0;
                        end else if (db_cnt == DB_LAST) begin
                            state_nxt   = S_RELEASED;
                            db_nxt      = '0;
                            release_nxt = 1'b1;
                        end else begin
                            db_nxt = db_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = S_RELEASED;
                        db_nxt    = '0;
                    end
                endcase
            end

            level_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_PEND);

            // Hold time only accrues on ticks that leave the button pressed, so a
            // release completing on the same tick can never fire btn_long.
            hold_nxt = hold_cnt;
            long_nxt = 1'b0;
            if (press_nxt) begin
                hold_nxt = '0;
            end else if (tick && level_nxt && (hold_cnt != HOLD_MAX)) begin
                hold_nxt = hold_cnt + 1'b1;
                long_nxt = (hold_cnt == HOLD_LAST);
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed bench for button_debounce
module tb_button_debounce;

    logic       clk;
    logic       reset_n;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_long;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int press_cnt[2];
    int rel_cnt[2];
    int long_cnt[2];
    int lvl0_cyc = 0;
    int nz_cyc   = 0;
    int tick_cyc = 0;
    int both_cyc = 0;

    button_debounce #(
        .NUM_BTN(2),
        .ACTIVE_LOW(1),
        .TICK_DIV(4),
        .DEBOUNCE_TICKS(3),
        .LONG_TICKS(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (btn_press[c])   press_cnt[c]++;
            if (btn_release[c]) rel_cnt[c]++;
            if (btn_long[c])    long_cnt[c]++;
        end
        if (btn_level[0]) lvl0_cyc++;
        if ((btn_level | btn_press | btn_release | btn_long) != 2'b00) nz_cyc++;
        if ((btn_press & btn_release) != 2'b00) both_cyc++;
        if (dut.tick) tick_cyc++;
    endtask

    function automatic logic pick(input int sel, input int ch);
        case (sel)
            0:       return btn_press[ch];
            1:       return btn_release[ch];
            default: return btn_long[ch];
        endcase
    endfunction

    // Returns the number of cycles until the pulse is seen, or -1 on timeout.
    task automatic wait_pulse(input int sel, input int ch, input int max_cyc, output int n);
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            step();
            if (pick(sel, ch)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic steps(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    int n;
    int p0, p1, r0, l0;

    initial begin
        for (int c = 0; c < 2; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
            long_cnt[c]  = 0;
        end
        reset_n = 1'b0;
        btn_in  = 2'b11;

        // 1: reset and idle
        steps(3);
        check("rst_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
        reset_n  = 1'b1;
        nz_cyc   = 0;
        tick_cyc = 0;
        steps(200);
        check("idle_nonzero_cycles", nz_cyc, 0);
        check("idle_tick_count", tick_cyc, 50);

        // 2 + 4: press ch0, hold through long press, then release
        btn_in[0] = 1'b0;
        wait_pulse(0, 0, 30, n);
        check("press_latency_in_window", int'(n >= 9 && n <= 18), 1);
        check("press_level0", int'(btn_level[0]), 1);
        check("press_ch1_quiet", int'({btn_level[1], btn_press[1]}), 0);
        wait_pulse(2, 0, 40, n);
        check("long_delay", n, 20);
        steps(40);
        check("long_once", long_cnt[0], 1);
        check("press_once", press_cnt[0], 1);
        check("ch1_no_press", press_cnt[1], 0);
        btn_in[0] = 1'b1;
        wait_pulse(1, 0, 30, n);
        check("release_seen", int'(n > 0), 1);
        steps(20);
        check("release_once", rel_cnt[0], 1);
        check("release_level0", int'(btn_level[0]), 0);

        // 3: bouncing input never qualifies
        p0 = press_cnt[0];
        lvl0_cyc = 0;
        for (int t = 0; t < 20; t++) begin
            btn_in[0] = t[0];
            steps(5);
        end
        btn_in[0] = 1'b1;
        steps(30);
        check("bounce_no_press", press_cnt[0] - p0, 0);
        check("bounce_level_low", lvl0_cyc, 0);

        // 5: short press then simultaneous press on both channels
        btn_in[0] = 1'b0;
        wait_pulse(0, 0, 30, n);
        check("short_press_seen", int'(n > 0), 1);
        l0 = long_cnt[0];
        steps(8);
        btn_in[0] = 1'b1;
        wait_pulse(1, 0, 30, n);
        check("short_release_delay", n, 12);
        steps(30);
        check("short_no_long", long_cnt[0] - l0, 0);
        btn_in = 2'b00;
        wait_pulse(0, 0, 30, n);
        check("dual_press_same_cycle", int'(btn_press), 3);

        // 6: reset mid-hold
        steps(5);
        check("dual_level_held", int'(btn_level), 3);
        r0 = rel_cnt[0] + rel_cnt[1];
        p1 = press_cnt[1];
        #1 reset_n = 1'b0;
        #1 check("async_reset_clears", int'({btn_level, btn_press, btn_release, btn_long}), 0);
        steps(3);
        reset_n = 1'b1;
        wait_pulse(0, 0, 30, n);
        check("repress_latency_in_window", int'(n >= 9 && n <= 18), 1);
        check("repress_ch1", press_cnt[1] - p1, 1);
        check("reset_no_release", rel_cnt[0] + rel_cnt[1] - r0, 0);
        check("never_press_and_release", both_cyc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
